// File: rtl/datapath_pkg.sv
// Shared definitions for the 5-stage MIPS datapath: NOP encoding,
// fetch-stage state encoding, PC increment and a saturating counter helper.
package datapath_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pc_register.sv
// 32-bit program counter register with synchronous reset to RESET_PC
// and a load enable; the fetch stage clears load_en to hold the PC.
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_q
);

  // PC update: reset wins, otherwise load the next PC when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (load_en) begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage and IF/ID pipeline register. Owns the fill/run/stall FSM,
// applies ID-resolved redirects with a one-bubble squash, and keeps
// saturating stall/squash statistics plus a sticky stall-timeout flag.
module instruction_fetch_stage
  import datapath_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Flush,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRdData,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] StallCount,
  output logic [31:0] SquashCount,
  output logic        StallTimeout
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, pc_plus4;
  logic         pc_load;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcplus4_q, pcplus4_d;
  logic         valid_q, valid_d;
  logic [31:0]  stall_count_q, stall_count_d;
  logic [31:0]  squash_count_q, squash_count_d;
  logic [31:0]  stall_run_q, stall_run_d;
  logic         timeout_q, timeout_d;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk    (Clk),
    .reset  (Reset),
    .load_en(pc_load),
    .pc_d   (pc_d),
    .pc_q   (pc_q)
  );

  assign pc_plus4 = pc_q + PC_INC;

  // Next-state logic: FILL always fetches sequentially; otherwise
  // Flush beats Jump, which beats BranchTaken, which beats sequential fetch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pc_load        = 1'b1;
    instr_d        = instr_q;
    pcplus4_d      = pcplus4_q;
    valid_d        = valid_q;
    stall_count_d  = stall_count_q;
    squash_count_d = squash_count_q;
    stall_run_d    = stall_run_q;
    timeout_d      = timeout_q;

    case (state_q)
      FILL: begin
        instr_d     = IMemRdData;
        pcplus4_d   = pc_plus4;
        valid_d     = 1'b1;
        pc_d        = pc_plus4;
        stall_run_d = 32'd0;
        state_d     = RUN;
      end
      default: begin
        if (Flush) begin
          pc_load       = 1'b0;
          stall_count_d = sat_inc(stall_count_q);
          stall_run_d   = sat_inc(stall_run_q);
          timeout_d     = timeout_q | (stall_run_d > MAX_STALL);
          state_d       = STALL;
        end else if (Jump || BranchTaken) begin
          pc_d           = Jump ? JumpTarget : BranchTarget;
          instr_d        = NOP_INSTR;
          pcplus4_d      = 32'd0;
          valid_d        = 1'b0;
          squash_count_d = sat_inc(squash_count_q);
          stall_run_d    = 32'd0;
          state_d        = RUN;
        end else begin
          instr_d     = IMemRdData;
          pcplus4_d   = pc_plus4;
          valid_d     = 1'b1;
          pc_d        = pc_plus4;
          stall_run_d = 32'd0;
          state_d     = RUN;
        end
      end
    endcase
  end

  // State, IF/ID and statistics registers; reset drops any pending redirect.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= FILL;
      instr_q        <= NOP_INSTR;
      pcplus4_q      <= 32'd0;
      valid_q        <= 1'b0;
      stall_count_q  <= 32'd0;
      squash_count_q <= 32'd0;
      stall_run_q    <= 32'd0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      pcplus4_q      <= pcplus4_d;
      valid_q        <= valid_d;
      stall_count_q  <= stall_count_d;
      squash_count_q <= squash_count_d;
      stall_run_q    <= stall_run_d;
      timeout_q      <= timeout_d;
    end
  end

  assign IMemAddr          = pc_q;
  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PCPlus4     = pcplus4_q;
  assign IF_ID_Valid       = valid_q;
  assign StallCount        = stall_count_q;
  assign SquashCount       = squash_count_q;
  assign StallTimeout      = timeout_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage. Instruction memory returns
// the address as the instruction word so fetched contents are predictable.
module tb_instruction_fetch_stage;

  logic        Clk;
  logic        Reset;
  logic        Flush;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] IMemAddr;
  logic [31:0] IMemRdData;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [31:0] StallCount;
  logic [31:0] SquashCount;
  logic        StallTimeout;

  int total = 0;
  int bad   = 0;

  instruction_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .MAX_STALL(16)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Flush            (Flush),
    .Jump             (Jump),
    .JumpTarget       (JumpTarget),
    .BranchTaken      (BranchTaken),
    .BranchTarget     (BranchTarget),
    .IMemAddr         (IMemAddr),
    .IMemRdData       (IMemRdData),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PCPlus4    (IF_ID_PCPlus4),
    .IF_ID_Valid      (IF_ID_Valid),
    .StallCount       (StallCount),
    .SquashCount      (SquashCount),
    .StallTimeout     (StallTimeout)
  );

  assign IMemRdData = IMemAddr;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle away from it.
  task automatic applyStimulus(input int edges);
    for (int i = 0; i < edges; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkIfId(input string tag, input logic [31:0] pc,
                           input logic [31:0] instr, input logic [31:0] pc4,
                           input logic valid);
    checkOutput({tag, ".pc"},    IMemAddr, pc);
    checkOutput({tag, ".instr"}, IF_ID_Instruction, instr);
    checkOutput({tag, ".pc4"},   IF_ID_PCPlus4, pc4);
    checkOutput({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, valid});
  endtask

  task automatic checkStats(input string tag, input logic [31:0] stalls,
                            input logic [31:0] squashes, input logic timeout);
    checkOutput({tag, ".stall"},   StallCount, stalls);
    checkOutput({tag, ".squash"},  SquashCount, squashes);
    checkOutput({tag, ".timeout"}, {31'd0, StallTimeout}, {31'd0, timeout});
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0; Jump = 1'b0; BranchTaken = 1'b0;
    JumpTarget = 32'h0; BranchTarget = 32'h0;

    // Reset state
    applyStimulus(1);
    checkIfId("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    checkStats("reset", 32'd0, 32'd0, 1'b0);
    Reset = 1'b0;

    // FILL then free-running fetch
    applyStimulus(1); checkIfId("fill",  32'h04, 32'h00, 32'h04, 1'b1);
    applyStimulus(1); checkIfId("seq2",  32'h08, 32'h04, 32'h08, 1'b1);
    applyStimulus(1); checkIfId("seq3",  32'h0C, 32'h08, 32'h0C, 1'b1);
    applyStimulus(1); checkIfId("seq4",  32'h10, 32'h0C, 32'h10, 1'b1);

    // Three-cycle stall at PC=0x10
    Flush = 1'b1;
    applyStimulus(1); checkIfId("stall1", 32'h10, 32'h0C, 32'h10, 1'b1);
    checkOutput("stall1.count", StallCount, 32'd1);
    applyStimulus(1); checkOutput("stall2.count", StallCount, 32'd2);
    applyStimulus(1); checkIfId("stall3", 32'h10, 32'h0C, 32'h10, 1'b1);
    checkStats("stall3", 32'd3, 32'd0, 1'b0);
    Flush = 1'b0;
    applyStimulus(1); checkIfId("resume", 32'h14, 32'h10, 32'h14, 1'b1);
    applyStimulus(3); checkIfId("at20",   32'h20, 32'h1C, 32'h20, 1'b1);

    // Taken branch to 0x40 costs one bubble
    BranchTaken = 1'b1; BranchTarget = 32'h40;
    applyStimulus(1); checkIfId("branch", 32'h40, 32'h0, 32'h0, 1'b0);
    checkOutput("branch.squash", SquashCount, 32'd1);
    BranchTaken = 1'b0;
    applyStimulus(1); checkIfId("btarget", 32'h44, 32'h40, 32'h44, 1'b1);

    // Flush overrides Jump; jump taken once Flush drops
    Flush = 1'b1; Jump = 1'b1; JumpTarget = 32'h80;
    applyStimulus(1); checkIfId("flushjump", 32'h44, 32'h40, 32'h44, 1'b1);
    checkStats("flushjump", 32'd4, 32'd1, 1'b0);
    Flush = 1'b0;
    applyStimulus(1); checkIfId("jump", 32'h80, 32'h0, 32'h0, 1'b0);
    checkOutput("jump.squash", SquashCount, 32'd2);
    Jump = 1'b0;
    applyStimulus(1); checkIfId("jtarget", 32'h84, 32'h80, 32'h84, 1'b1);

    // Stall timeout: 16 edges quiet, 17th sets it, sticky afterwards
    Flush = 1'b1;
    applyStimulus(16); checkStats("stall16", 32'd20, 32'd2, 1'b0);
    applyStimulus(1);  checkStats("stall17", 32'd21, 32'd2, 1'b1);
    Flush = 1'b0;
    applyStimulus(1); checkIfId("post_to", 32'h88, 32'h84, 32'h88, 1'b1);
    checkOutput("post_to.timeout", {31'd0, StallTimeout}, 32'd1);

    // PC wrap at the top of the address space
    Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
    applyStimulus(1); checkOutput("wrapjmp.pc", IMemAddr, 32'hFFFF_FFFC);
    Jump = 1'b0;
    applyStimulus(1); checkIfId("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Reset during a stall at PC=0x100 with a redirect pending
    Jump = 1'b1; JumpTarget = 32'h100;
    applyStimulus(1); checkOutput("to100.pc", IMemAddr, 32'h100);
    Jump = 1'b0; Flush = 1'b1;
    applyStimulus(1); checkOutput("stall100.pc", IMemAddr, 32'h100);
    checkStats("stall100", 32'd22, 32'd4, 1'b1);
    Reset = 1'b1; Jump = 1'b1; JumpTarget = 32'h200;
    applyStimulus(1); checkIfId("midreset", 32'h0, 32'h0, 32'h0, 1'b0);
    checkStats("midreset", 32'd0, 32'd0, 1'b0);

    // FILL ignores Flush and Jump
    Reset = 1'b0;
    applyStimulus(1); checkIfId("refill", 32'h04, 32'h00, 32'h04, 1'b1);
    checkStats("refill", 32'd0, 32'd0, 1'b0);
    Flush = 1'b0; Jump = 1'b0;
    applyStimulus(1); checkIfId("reseq", 32'h08, 32'h04, 32'h08, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage plus IF/ID pipeline register for the 5-stage MIPS datapath. Holds the PC, drives the instruction-memory address, and captures instruction and PC+4 into IF/ID. It sits directly upstream of the hazard detection unit and decode. It obeys that unit's `Flush` (stall) output, applies branch/jump redirects resolved in ID, squashes wrong-path fetches, and keeps stall/bubble statistics for the bench.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `MAX_STALL`, default 16: consecutive stall cycles allowed before `StallTimeout` asserts.

Ports:
- `Clk`  in  1: the single clock; all state updates on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `Flush`  in  1: stall request from the hazard detection unit. While high, PC and IF/ID hold.
- `Jump`  in  1: jump/jal/jr resolved in ID.
- `JumpTarget`  in  32: jump destination.
- `BranchTaken`  in  1: conditional branch taken in ID.
- `BranchTarget`  in  32: branch destination.
- `IMemAddr`  out  32: instruction-memory address, combinationally equal to the PC.
- `IMemRdData`  in  32: asynchronous-read instruction word for `IMemAddr`.
- `IF_ID_Instruction`  out  32: instruction presented to decode.
- `IF_ID_PCPlus4`  out  32: address of the fetched instruction + 4.
- `IF_ID_Valid`  out  1: 0 marks a bubble. Decode treats the instruction as NOP.
- `StallCount`  out  32: cycles in which `Flush` held the stage.
- `SquashCount`  out  32: wrong-path fetches squashed by redirects.
- `StallTimeout`  out  1: sticky; set when a stall run exceeds `MAX_STALL`.

## Operation
- States: `FILL`, `RUN`, `STALL`.
- Reset behaviour: reset enters `FILL`. PC=`RESET_PC`; IF/ID instruction=0 (sll $0 NOP); PCPlus4=0; Valid=0; both counters=0; `StallTimeout`=0; stall-run counter=0.
- `FILL`: lasts one cycle.
  - IF/ID captures the fetch at `RESET_PC` with Valid=1.
  - PC becomes `RESET_PC`+4.
  - Next state is `RUN`. `Flush`, `Jump` and `BranchTaken` are ignored in `FILL`, since no valid instruction is in decode yet.
- Per-cycle priority in `RUN`/`STALL`: `Reset` > `Flush` > `Jump` > `BranchTaken` > sequential.
- `Flush`=1:
  - PC, IF/ID and Valid hold.
  - `StallCount`+1; stall-run counter+1; state=`STALL`.
  - Redirect inputs are ignored, because the branch operands in ID are not yet valid.
- Redirect (`Jump`, or `BranchTaken` with `Flush`=0):
  - PC <= target (`JumpTarget` when `Jump`=1, else `BranchTarget`).
  - IF/ID <= instruction 0, Valid 0, PCPlus4 0. There is no delay slot; the wrong-path fetch is squashed.
  - `SquashCount`+1; state=`RUN`; stall-run counter cleared.
- Sequential (no flush, no redirect):
  - IF/ID <= {`IMemRdData`, PC+4}, Valid=1.
  - PC <= PC+4; state=`RUN`; stall-run counter cleared.
- Timeout: in `STALL`, when the stall-run counter reaches `MAX_STALL`+1, `StallTimeout` sets and stays set until `Reset`.
- Arithmetic:
  - PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 silently.
  - Counters saturate at 32'hFFFF_FFFF.
  - Targets are used as given; the low two bits are not checked.
- Reset mid-stall or mid-redirect: all state returns to reset values on that edge, and the pending redirect is lost.

## Timing
- `IMemAddr` follows PC with zero latency.
- An instruction reaches IF/ID one edge after its address is presented.
- A redirect sampled at edge N puts the target on `IMemAddr` after N. The target instruction is in IF/ID after N+1, so it costs exactly one bubble.
- A stall of K cycles delays all IF/ID contents by K edges and changes no values.
- `Flush` and the redirect inputs are sampled only at the rising edge; glitches between edges have no effect.

## Structure
- Shared package `datapath_pkg` holds:
  - the NOP encoding (32'h0000_0000);
  - the state encoding `FILL`=2'd0, `RUN`=2'd1, `STALL`=2'd2;
  - the PC increment constant 4.
- One sub-module: `pc_register`, a 32-bit register with synchronous reset to `RESET_PC` and a load enable. The IF/ID register, FSM and counters stay in the top module.

## Test plan
- Reset, then 4 free-running cycles, with `IMemRdData` = address: PCPlus4 sequence 4, 8, 12, 16. Instruction 0, 4, 8, 12. Valid=1 from the first post-`FILL` edge.
- `Flush` high for 3 cycles at PC=0x10:
  - PC holds 0x10;
  - IF/ID holds {0x0C, PCPlus4 0x10};
  - `StallCount`=3;
  - fetch resumes at 0x10.
- `BranchTaken`=1, `BranchTarget`=0x40 at PC=0x20: next edge PC=0x40 with an IF/ID bubble (Valid=0). The following edge gives IF/ID PCPlus4=0x44. `SquashCount`=1.
- `Flush`=1 together with `Jump`=1, `JumpTarget`=0x80: PC holds and there is no squash. Once `Flush` drops with `Jump` still high, the redirect to 0x80 occurs.
- `Flush` held 17 cycles with `MAX_STALL`=16: `StallTimeout` rises on the 17th edge and remains 1 after `Flush` drops. `Reset` clears it.
- `Reset` asserted during a stall with PC=0x100: next edge PC=`RESET_PC`, Valid=0, counters=0, state `FILL`.
